stim_scheduler: RTL and testbench

//  Closed-loop stimulation sequencer fed by the weighted-sum classifier (LL/NE/PS/theta/alpha/beta votes).

---
 rtl/stim_scheduler.sv | 132 +++++++++++++
 tb/tb_stim_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/stim_scheduler.sv
// rtl/stim_scheduler.sv - closed-loop stimulation sequencer: consecutive-detect trigger, pulse train, refractory lockout
module stim_scheduler #(
  parameter int WS_WIDTH       = 12,
  parameter int THRESHOLD      = 300,
  parameter int CONSEC_REQ     = 3,
  parameter int PULSE_ON       = 200,
  parameter int PULSE_OFF      = 800,
  parameter int N_PULSES       = 5,
  parameter int REFRACT_CYCLES = 10000,
  parameter int TIMER_WIDTH    = 16,
  parameter int CNT_WIDTH      = 4,
  parameter int STIMCNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       ws_valid,
  input  logic signed [WS_WIDTH-1:0] weighted_sum,
  output logic                       stimulation,
  output logic                       busy,
  output logic [1:0]                 state_out,
  output logic [CNT_WIDTH-1:0]       consec_cnt,
  output logic [STIMCNT_WIDTH-1:0]   stim_count
);

  typedef enum logic [1:0] {
    DETECT   = 2'd0,
    STIM_ON  = 2'd1,
    STIM_OFF = 2'd2,
    REFRACT  = 2'd3
  } state_t;

  localparam logic signed [WS_WIDTH-1:0] THRESH      = WS_WIDTH'(THRESHOLD);
  localparam logic [CNT_WIDTH-1:0]       CONSEC_LAST = CNT_WIDTH'(CONSEC_REQ - 1);
  localparam logic [CNT_WIDTH-1:0]       PULSE_LAST  = CNT_WIDTH'(N_PULSES - 1);
  localparam logic [TIMER_WIDTH-1:0]     ON_LAST     = TIMER_WIDTH'(PULSE_ON - 1);
  localparam logic [TIMER_WIDTH-1:0]     OFF_LAST    = TIMER_WIDTH'(PULSE_OFF - 1);
  localparam logic [TIMER_WIDTH-1:0]     REF_LAST    = TIMER_WIDTH'(REFRACT_CYCLES - 1);

  state_t                   state, state_nxt;
  logic [TIMER_WIDTH-1:0]   timer, timer_nxt;
  logic [CNT_WIDTH-1:0]     pulse, pulse_nxt;
  logic [CNT_WIDTH-1:0]     consec_nxt;
  logic [STIMCNT_WIDTH-1:0] stim_count_nxt;
  logic                     detect;

  assign detect = (weighted_sum >= THRESH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DETECT;
      timer      <= '0;
      pulse      <= '0;
      consec_cnt <= '0;
      stim_count <= '0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      pulse      <= pulse_nxt;
      consec_cnt <= consec_nxt;
      stim_count <= stim_count_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    pulse_nxt      = pulse;
    consec_nxt     = consec_cnt;
    stim_count_nxt = stim_count;
    if (en) begin
      state_nxt  = DETECT;
      timer_nxt  = '0;
      pulse_nxt  = '0;
      consec_nxt = '0;
    end else begin
      case (state)
        DETECT: begin
          if (ws_valid) begin
            if (!detect) begin
              consec_nxt = '0;
            end else if (consec_cnt == CONSEC_LAST) begin
              state_nxt  = STIM_ON;
              consec_nxt = '0;
              timer_nxt  = '0;
              pulse_nxt  = '0;
              if (stim_count != '1) stim_count_nxt = stim_count + STIMCNT_WIDTH'(1);
            end else begin
              consec_nxt = consec_cnt + CNT_WIDTH'(1);
            end
          end
        end
        STIM_ON: begin
          if (timer == ON_LAST) begin
            state_nxt = STIM_OFF;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + TIMER_WIDTH'(1);
          end
        end
        STIM_OFF: begin
          if (timer == OFF_LAST) begin
            timer_nxt = '0;
            if (pulse == PULSE_LAST) begin
              state_nxt = REFRACT;
            end else begin
              pulse_nxt = pulse + CNT_WIDTH'(1);
              state_nxt = STIM_ON;
            end
          end else begin
            timer_nxt = timer + TIMER_WIDTH'(1);
          end
        end
        default: begin
          // ws_valid is dropped here; consec_cnt was cleared on trigger and stays 0
          if (timer == REF_LAST) begin
            state_nxt  = DETECT;
            timer_nxt  = '0;
            consec_nxt = '0;
          end else begin
            timer_nxt = timer + TIMER_WIDTH'(1);
          end
        end
      endcase
    end
  end

  assign stimulation = (state == STIM_ON);
  assign busy        = (state != DETECT);
  assign state_out   = state;

endmodule

// File: tb/tb_stim_scheduler.sv
// tb/tb_stim_scheduler.sv - self-checking bench for stim_scheduler with an elapsed-time train model
module tb_stim_scheduler;

  localparam int ON     = 2;
  localparam int OFF    = 3;
  localparam int NP     = 2;
  localparam int REF    = 4;
  localparam int PERIOD = ON + OFF;
  localparam int TRAIN  = NP * PERIOD;

  logic        clk = 0;
  logic        rst = 1;
  logic        en = 0;
  logic        ws_valid = 0;
  logic signed [11:0] weighted_sum = '0;
  logic        stimulation;
  logic        busy;
  logic [1:0]  state_out;
  logic [3:0]  consec_cnt;
  logic [1:0]  stim_count;

  int checks = 0;
  int failures = 0;

  stim_scheduler #(
    .WS_WIDTH(12), .THRESHOLD(300), .CONSEC_REQ(3), .PULSE_ON(ON), .PULSE_OFF(OFF),
    .N_PULSES(NP), .REFRACT_CYCLES(REF), .TIMER_WIDTH(16), .CNT_WIDTH(4), .STIMCNT_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ws_valid(ws_valid), .weighted_sum(weighted_sum),
    .stimulation(stimulation), .busy(busy), .state_out(state_out),
    .consec_cnt(consec_cnt), .stim_count(stim_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a train is just elapsed cycles since trigger, decoded arithmetically
  bit started = 0;
  bit m_active = 0;
  int m_elapsed = 0;
  int m_consec = 0;
  int m_count = 0;

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      m_active = 0; m_elapsed = 0; m_consec = 0; m_count = 0;
    end else if (en) begin
      m_active = 0; m_elapsed = 0; m_consec = 0;
    end else if (m_active) begin
      m_elapsed++;
      if (m_elapsed == TRAIN + REF) begin
        m_active = 0; m_elapsed = 0;
      end
    end else if (ws_valid) begin
      if (int'(weighted_sum) >= 300) begin
        if (m_consec + 1 == 3) begin
          m_active = 1; m_elapsed = 0; m_consec = 0;
          m_count = (m_count == 3) ? 3 : m_count + 1;
        end else begin
          m_consec++;
        end
      end else begin
        m_consec = 0;
      end
    end
  end

  always @(negedge clk) begin
    int st;
    if (started) begin
      if (!m_active) st = 0;
      else if (m_elapsed < TRAIN) st = ((m_elapsed % PERIOD) < ON) ? 1 : 2;
      else st = 3;
      chk("model_state", state_out, st);
      chk("model_stim", stimulation, int'(st == 1));
      chk("model_busy", busy, int'(st != 0));
      chk("model_consec", consec_cnt, m_consec);
      chk("model_stim_count", stim_count, m_count);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic valid(input int s);
    ws_valid = 1;
    weighted_sum = s[11:0];
    @(negedge clk);
    ws_valid = 0;
  endtask

  task automatic trigger();
    valid(500); valid(500); valid(500);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", busy, 0);
  endtask

  initial begin
    logic [9:0] pat;
    int exp_cnt [5] = '{1, 2, 3, 3, 3};
    int n;

    idle(2);
    chk("reset_state", state_out, 0);
    chk("reset_stim_count", stim_count, 0);
    rst = 0;
    idle(1);

    // 1: 300,301,500 with gaps then exact train waveform
    valid(300); idle(2); valid(301); idle(1); valid(500);
    for (int i = 0; i < 10; i++) begin
      pat[9-i] = stimulation;
      @(negedge clk);
    end
    chk("t1_pattern", pat, 10'b1100011000);
    for (int i = 0; i < 4; i++) begin
      chk("t1_refract", state_out, 3);
      @(negedge clk);
    end
    chk("t1_detect", state_out, 0);
    chk("t1_stim_count", stim_count, 1);

    // 2: a below-threshold window resets the run
    valid(300); valid(299); valid(300); valid(300);
    chk("t2_consec", consec_cnt, 2);
    chk("t2_no_stim", stimulation, 0);
    valid(300);
    chk("t2_stim", stimulation, 1);
    wait_idle();

    // 3: signed compare boundaries
    valid(299); valid(-1); valid(-2048);
    chk("t3_neg", consec_cnt, 0);
    valid(300);
    chk("t3_boundary", consec_cnt, 1);
    valid(2047);
    chk("t3_max", consec_cnt, 2);
    valid(100);

    // 4: valid held high through train/refract is ignored
    ws_valid = 1;
    weighted_sum = 12'sd500;
    idle(3);
    chk("t4_trig", stimulation, 1);
    n = 0;
    while (busy && n < 40) begin
      chk("t4_consec_zero", consec_cnt, 0);
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!stimulation && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t4_fresh_valids", n, 3);
    ws_valid = 0;
    wait_idle();

    // 5: enable abort and reset in refract
    trigger();
    idle(1);
    en = 1;
    idle(1);
    chk("t5_abort_stim", stimulation, 0);
    chk("t5_abort_state", state_out, 0);
    chk("t5_kept_count", stim_count, 3);
    valid(500);
    chk("t5_en_blocks", consec_cnt, 0);
    en = 0;
    trigger();
    n = 0;
    while (state_out != 3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_refract", state_out, 3);
    rst = 1;
    idle(1);
    chk("t5_rst_all", {stimulation, busy, state_out, consec_cnt, stim_count}, 0);
    rst = 0;
    idle(1);

    // 6: stim_count saturates
    for (int i = 0; i < 5; i++) begin
      trigger();
      chk("t6_stim_count", stim_count, exp_cnt[i]);
      wait_idle();
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
